// File: rtl/riscv_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package riscv_loader_pkg;

    localparam int unsigned LEN_BYTES = 2;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned LEN_W     = LEN_BYTES * BYTE_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_e;

endpackage

// File: rtl/loader_word_asm.sv
// Packs little-endian stream bytes into 32-bit words; pulses word_valid for
// one cycle, with the completed word registered, after each 4th byte.
module loader_word_asm
    import riscv_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              word_last_c,
    output logic [WORD_W-1:0] asm_word,
    output logic              word_valid
);

    logic [1:0]        byte_cnt;
    logic [WORD_W-1:0] shreg;

    // The byte being accepted now completes a word.
    assign word_last_c = byte_en && (byte_cnt == 2'd3);

    // Byte lane insert; the full word is captured with its final byte so the
    // next word's first byte may land in the same cycle as the write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_cnt   <= '0;
            shreg      <= '0;
            asm_word   <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_cnt <= '0;
            end else if (byte_en) begin
                byte_cnt                    <= byte_cnt + 2'd1;
                shreg[{byte_cnt, 3'b000} +: BYTE_W] <= byte_in;
                if (byte_cnt == 2'd3) begin
                    asm_word   <= {byte_in, shreg[WORD_W-BYTE_W-1:0]};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/riscv_imem_loader.sv
// Framed byte-stream loader writing the instruction memory and gating core reset.
module riscv_imem_loader
    import riscv_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wd,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  words_loaded
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    loader_state_e     state;
    logic [BYTE_W-1:0] len_lo;
    logic [LEN_W-1:0]  n_words;
    logic [BYTE_W-1:0] csum;

    logic              xfer_c;
    logic              idle_like_c;
    logic              asm_clear_c;
    logic              byte_en_c;
    logic              word_last_c;
    logic [LEN_W-1:0]  len_n_c;

    // Handshake and datapath enables.
    assign xfer_c      = in_valid && in_ready;
    assign idle_like_c = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
    assign asm_clear_c = start && idle_like_c;
    assign byte_en_c   = xfer_c && (state == ST_DATA);
    assign len_n_c     = {in_data, len_lo};

    loader_word_asm u_word_asm (
        .clk         (clk),
        .rst         (rst),
        .clear       (asm_clear_c),
        .byte_en     (byte_en_c),
        .byte_in     (in_data),
        .word_last_c (word_last_c),
        .asm_word    (mem_wd),
        .word_valid  (mem_we)
    );

    // Load FSM with registered status outputs, word index and checksum.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            core_rst     <= 1'b1;
            words_loaded <= '0;
            mem_addr     <= '0;
            len_lo       <= '0;
            n_words      <= '0;
            csum         <= '0;
        end else begin
            if (word_last_c) begin
                mem_addr     <= ADDR_W'(words_loaded);
                words_loaded <= words_loaded + LEN_W'(1);
            end
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state        <= ST_LEN0;
                        in_ready     <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        core_rst     <= 1'b1;
                        words_loaded <= '0;
                        csum         <= '0;
                    end
                end
                ST_LEN0: begin
                    if (xfer_c) begin
                        len_lo <= in_data;
                        state  <= ST_LEN1;
                    end
                end
                ST_LEN1: begin
                    if (xfer_c) begin
                        n_words <= len_n_c;
                        if (32'(len_n_c) > DEPTH) begin
                            state    <= ST_ERR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end else if (len_n_c == '0) begin
                            state <= ST_CSUM;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer_c) begin
                        csum <= csum ^ in_data;
                        if (word_last_c && (words_loaded == n_words - LEN_W'(1))) begin
                            state <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (xfer_c) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == csum) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    core_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule
